// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default link parameters
// used by both ends of the AES core's serial link.
package uart_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 434;
   localparam int DEFAULT_DATA_WIDTH   = 8;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      RX_START     = 3'd1,
      RX_DATA      = 3'd2,
      RX_STOP      = 3'd3,
      RX_WAIT_IDLE = 3'd4
   } rx_state_e;

   // Mid-bit offset used to verify the start bit before committing to a frame.
   function automatic int half_count(input int clks_per_bit);
      return (clks_per_bit - 1) / 2;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// N-flop synchronizer for an asynchronous input; flops reset to a configurable
// value so an idle-high line does not look like activity coming out of reset.
module uart_rx_sync #(
   parameter int   STAGES      = 2,
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic async_in,
   output logic sync_out
);

   logic [STAGES-1:0] stages;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stages <= {STAGES{RESET_VALUE}};
      end else begin
         stages <= {stages[STAGES-2:0], async_in};
      end
   end

   assign sync_out = stages[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of a synchronized serial line, one-cycle
// strobes for good bytes and framing errors.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  rx_serial_in,
   output logic [DATA_WIDTH-1:0] rx_byte_out,
   output logic                  rx_dv,
   output logic                  rx_frame_err,
   output logic                  rx_active
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_WIDTH) + 1;

   localparam logic [CW-1:0] HALF     = CW'(half_count(CLKS_PER_BIT));
   localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

   rx_state_e             state;
   logic [CW-1:0]         clk_count;
   logic [IW-1:0]         bit_index;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic                  rx_sync;

   uart_rx_sync #(
      .STAGES      (2),
      .RESET_VALUE (1'b1)
   ) sync_inst (
      .clk      (clk),
      .reset_n  (reset_n),
      .async_in (rx_serial_in),
      .sync_out (rx_sync)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         clk_count    <= '0;
         bit_index    <= '0;
         shift_reg    <= '0;
         rx_byte_out  <= '0;
         rx_dv        <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         rx_dv        <= 1'b0;
         rx_frame_err <= 1'b0;
         case (state)
            IDLE: begin
               clk_count <= '0;
               bit_index <= '0;
               if (!rx_sync) begin
                  state <= RX_START;
               end
            end
            // A start bit that is already high again at mid-bit is a glitch.
            RX_START: begin
               if (clk_count == HALF) begin
                  clk_count <= '0;
                  state     <= rx_sync ? IDLE : RX_DATA;
               end else begin
                  clk_count <= clk_count + CW'(1);
               end
            end
            RX_DATA: begin
               if (clk_count == LAST) begin
                  clk_count                       <= '0;
                  shift_reg[bit_index[IW-2:0]]    <= rx_sync;
                  if (bit_index == LAST_BIT) begin
                     state <= RX_STOP;
                  end else begin
                     bit_index <= bit_index + IW'(1);
                  end
               end else begin
                  clk_count <= clk_count + CW'(1);
               end
            end
            RX_STOP: begin
               if (clk_count == LAST) begin
                  clk_count <= '0;
                  if (rx_sync) begin
                     rx_byte_out <= shift_reg;
                     rx_dv       <= 1'b1;
                     state       <= IDLE;
                  end else begin
                     rx_frame_err <= 1'b1;
                     state        <= RX_WAIT_IDLE;
                  end
               end else begin
                  clk_count <= clk_count + CW'(1);
               end
            end
            // A break or stuck-low line must not be mistaken for a new start bit.
            RX_WAIT_IDLE: begin
               if (rx_sync) begin
                  state <= IDLE;
               end
            end
            default: begin
               state        <= IDLE;
               clk_count    <= 'x;
               bit_index    <= 'x;
               shift_reg    <= 'x;
               rx_byte_out  <= 'x;
               rx_dv        <= 1'bx;
               rx_frame_err <= 1'bx;
            end
         endcase
      end
   end

   assign rx_active = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at CLKS_PER_BIT=16: directed frames plus a randomized-gap
// loopback run, checked against a byte-level scoreboard of what was sent.
module tb_uart_rx;

   localparam int CLKS = 16;
   localparam int DW   = 8;
   // Line fall to strobe: 2 sync edges + state edge, then HALF + 9 bits + 1.
   localparam int STROBE_LAT = 3 + (CLKS - 1) / 2 + 9 * CLKS + 1;

   logic          clk          = 1'b0;
   logic          reset_n      = 1'b0;
   logic          rx_serial_in = 1'b1;
   logic [DW-1:0] rx_byte_out;
   logic          rx_dv;
   logic          rx_frame_err;
   logic          rx_active;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] got_q[$];
   int err_count       = 0;
   int both_count      = 0;
   int last_strobe_cyc = -1;

   uart_rx #(
      .CLKS_PER_BIT (CLKS),
      .DATA_WIDTH   (DW)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .rx_serial_in (rx_serial_in),
      .rx_byte_out  (rx_byte_out),
      .rx_dv        (rx_dv),
      .rx_frame_err (rx_frame_err),
      .rx_active    (rx_active)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every strobe the receiver emits, sampled mid-cycle.
   always @(negedge clk) begin
      if (rx_dv) begin
         got_q.push_back(rx_byte_out);
         last_strobe_cyc = cyc;
      end
      if (rx_frame_err) begin
         err_count++;
         last_strobe_cyc = cyc;
      end
      if (rx_dv && rx_frame_err) both_count++;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one frame starting at the current negedge; line is left at stop_bit.
   task automatic send_frame(input logic [DW-1:0] data, input logic stop_bit,
                             input bit expect_good, output int fall_cyc);
      fall_cyc     = cyc;
      rx_serial_in = 1'b0;
      idle(CLKS);
      for (int i = 0; i < DW; i++) begin
         rx_serial_in = data[i];
         idle(CLKS);
      end
      rx_serial_in = stop_bit;
      idle(CLKS);
      if (expect_good && stop_bit) exp_q.push_back(data);
   endtask

   initial begin
      int            f;
      int            f2;
      logic [DW-1:0] aborted;

      // Reset state
      idle(3);
      check("reset_dv", rx_dv, 1'b0);
      check("reset_err", rx_frame_err, 1'b0);
      check("reset_active", rx_active, 1'b0);
      check("reset_byte", rx_byte_out, 8'h00);
      reset_n = 1'b1;
      idle(2);

      // Clean frame with strobe latency
      send_frame(8'hA5, 1'b1, 1'b1, f);
      idle(4);
      check("clean_count", got_q.size(), 1);
      check("clean_byte", rx_byte_out, 8'hA5);
      check("clean_latency", last_strobe_cyc - f, STROBE_LAT);
      check("clean_no_err", err_count, 0);

      // Glitch on the line: start rejected at mid-bit
      rx_serial_in = 1'b0;
      f = cyc;
      idle(4);
      rx_serial_in = 1'b1;
      idle(6);
      check("glitch_active_at_half", rx_active, 1'b1);
      idle(1);
      check("glitch_back_idle", rx_active, 1'b0);
      idle(20);
      check("glitch_no_dv", got_q.size(), 1);
      check("glitch_no_err", err_count, 0);
      check("glitch_byte_kept", rx_byte_out, 8'hA5);

      // Framing error followed by a held-low line
      send_frame(8'h3C, 1'b0, 1'b0, f);
      idle(40);
      check("ferr_count", err_count, 1);
      check("ferr_latency", last_strobe_cyc - f, STROBE_LAT);
      check("ferr_no_dv", got_q.size(), 1);
      check("ferr_byte_kept", rx_byte_out, 8'hA5);
      check("ferr_wait_idle", rx_active, 1'b1);
      rx_serial_in = 1'b1;
      idle(5);
      check("ferr_released", rx_active, 1'b0);

      // Back-to-back frames with no idle gap
      send_frame(8'h00, 1'b1, 1'b1, f);
      send_frame(8'hFF, 1'b1, 1'b1, f2);
      idle(4);
      check("b2b_count", got_q.size(), 3);
      check("b2b_latency2", last_strobe_cyc - f2, STROBE_LAT);
      check("b2b_last", rx_byte_out, 8'hFF);

      // Reset pulse during data bit 3; upper bits high so the tail looks idle
      aborted = {5'b11111, 3'($urandom)};
      fork
         send_frame(aborted, 1'b1, 1'b0, f);
         begin
            idle(70);
            reset_n = 1'b0;
            idle(1);
            check("midreset_active", rx_active, 1'b0);
            check("midreset_byte", rx_byte_out, 8'h00);
            check("midreset_dv", rx_dv, 1'b0);
            check("midreset_err", rx_frame_err, 1'b0);
            reset_n = 1'b1;
         end
      join
      idle(4);
      check("midreset_no_dv", got_q.size(), 3);
      send_frame(8'h5A, 1'b1, 1'b1, f);
      idle(4);
      check("after_reset_byte", rx_byte_out, 8'h5A);
      check("after_reset_latency", last_strobe_cyc - f, STROBE_LAT);

      // Loopback-style run: all byte values with random inter-frame gaps
      for (int b = 0; b < 256; b++) begin
         idle($urandom_range(0, 3));
         send_frame(8'(b), 1'b1, 1'b1, f);
      end
      idle(6);

      check("total_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check($sformatf("byte_%0d", i), got_q[i], exp_q[i]);
      end
      check("total_err", err_count, 1);
      check("never_both", both_count, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the AES-128 core's serial link: recovers 8N1 frames from a single asynchronous line and presents each byte to the core's input side. It is the receiving end of the same link the transmitter drives. It uses the same baud parameterisation as the transmitter, so a matched pair is loopback-compatible. Every accepted byte produces a one-cycle valid strobe. Framing violations are reported, not delivered.

## Interface
- CLKS_PER_BIT, 434, clk cycles per bit (115200 baud at 50 MHz); must be >= 4.
- DATA_WIDTH, 8, data bits per frame, LSB first.
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
- rx_serial_in  input  1  asynchronous serial line; idles high.
- rx_byte_out  output  DATA_WIDTH  last good byte; held until the next good byte; reset 0.
- rx_dv  output  1  one-cycle strobe, rx_byte_out updated this cycle; reset 0.
- rx_frame_err  output  1  one-cycle strobe, stop bit sampled low; reset 0.
- rx_active  output  1  high in every state except IDLE; reset 0.

## Operation
- rx_serial_in passes a 2-FF synchronizer (reset value 1) giving rx_sync. Only rx_sync is used downstream.
- clk_count width is $clog2(CLKS_PER_BIT). HALF = (CLKS_PER_BIT-1)/2 (integer). bit_index width is $clog2(DATA_WIDTH)+1.
- States:
  - IDLE: clk_count=0, bit_index=0. If rx_sync==0, go to RX_START.
  - RX_START: clk_count increments. At clk_count==HALF:
    - rx_sync==0: go to RX_DATA, clk_count=0.
    - rx_sync==1: glitch; go to IDLE with no strobe.
  - RX_DATA: clk_count increments. At clk_count==CLKS_PER_BIT-1:
    - shift_reg[bit_index] <= rx_sync, clk_count=0.
    - bit_index==DATA_WIDTH-1: go to RX_STOP. Otherwise bit_index++.
  - RX_STOP: at clk_count==CLKS_PER_BIT-1:
    - rx_sync==1: rx_byte_out <= shift_reg, rx_dv=1, go to IDLE.
    - rx_sync==0: rx_frame_err=1, rx_byte_out unchanged, go to RX_WAIT_IDLE.
  - RX_WAIT_IDLE: stay until rx_sync==1, then go to IDLE. This prevents a break or stuck-low line from re-triggering a start.
- rx_dv and rx_frame_err are never high together. Each is high for exactly one cycle per frame.
- Illegal state encoding: drive all registers to X in simulation; next state is IDLE.
- Reset mid-frame: the next edge with reset_n==0 returns to IDLE. All outputs and counters clear, synchronizer flops are set to 1, and the partial byte is discarded.

## Timing
- Cycle 0 is the first cycle in RX_START. RX_START is entered 3 edges after rx_serial_in falls (2-FF sync + state register).
- Start verification happens at cycle HALF.
- Data bit n is sampled at cycle HALF + (n+1)·CLKS_PER_BIT.
- The stop bit is sampled at cycle HALF + (DATA_WIDTH+1)·CLKS_PER_BIT. rx_dv or rx_frame_err is high in the following cycle.
- Example at defaults: HALF=216. Stop is sampled at cycle 4122 and rx_dv is high at cycle 4123.
- Back-to-back frames: the machine is back in IDLE in the cycle after stop sampling, about half a bit before the nominal stop end. A start bit arriving immediately is therefore caught.
- Tolerates about ±4% baud mismatch at CLKS_PER_BIT=434.

## Structure
- uart_pkg holds:
  - rx_state_e (IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE; 3-bit encoding).
  - Default CLKS_PER_BIT and DATA_WIDTH constants, shared with the transmitter.
- Sub-module uart_rx_sync: parameterisable N-flop synchronizer with reset value 1. It is reusable for other asynchronous inputs.
- All outputs are registered. rx_active is decoded from the state register.

## Test plan
Benches run with CLKS_PER_BIT=16 (HALF=7).
- Clean frame 0xA5 -> rx_byte_out=0xA5 and rx_dv high exactly 1 cycle, at 7+9·16+1=152 cycles after RX_START entry. rx_frame_err stays 0.
- Glitch: line low for 4 clk, then high -> RX_START exits to IDLE at cycle 7. No rx_dv, no rx_frame_err, and rx_byte_out keeps its prior value.
- Frame 0x3C with stop bit low, then line held low 40 clk -> rx_frame_err 1 cycle. rx_byte_out unchanged, and the machine stays in RX_WAIT_IDLE until the line rises.
- Back-to-back frames 0x00 then 0xFF, each starting the moment the previous stop bit ends -> two rx_dv strobes with 0x00 then 0xFF, and no missed start.
- reset_n low for 1 cycle during data bit 3 -> next cycle in IDLE with rx_active=0 and all outputs 0. A following frame 0x5A is received correctly.
- Loopback against the transmitter (same CLKS_PER_BIT) with 256 sequential bytes -> every byte matches and there are zero framing errors.
